// File: rtl/parity_frame_tx_ctrl_pkg.sv
// Shared types and constants for the parity-framed serial transmitter.
package parity_frame_tx_ctrl_pkg;

    localparam int FRAME_BITS = 12;
    localparam int DATA_W     = 9;
    localparam int BIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

endpackage

// File: rtl/parity_frame_tx_ctrl_parity.sv
// 9-bit parity generator: even-parity bit and its odd-parity complement.
module parity_generator_9_bits (
    input  logic [8:0] data_i,
    output logic       ep_o,
    output logic       op_o
);

    assign ep_o = ^data_i;
    assign op_o = ~ep_o;

endmodule

// File: rtl/parity_frame_tx_ctrl.sv
// Frames a 9-bit word as start, 9 data bits LSB first, parity, stop and
// shifts it out on a registered serial line, CLKS_PER_BIT cycles per bit.
module parity_frame_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = parity_frame_tx_ctrl_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              odd_sel,
    output logic              tx_out,
    output logic              busy,
    output logic              done
);
    import parity_frame_tx_ctrl_pkg::*;

    localparam int                   BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0]    BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(DATA_W - 1);

    state_t                 state_q;
    logic [BAUD_W-1:0]      baud_q;
    logic [BIT_CNT_W-1:0]   bit_q;
    logic [DATA_W-1:0]      shift_q;
    logic                   par_q;
    logic                   tx_out_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   ready_q;

    logic                   ep;
    logic                   op;
    logic                   baud_wrap;
    logic                   accept;

    parity_generator_9_bits u_parity (
        .data_i (tx_data),
        .ep_o   (ep),
        .op_o   (op)
    );

    assign baud_wrap = (baud_q == BAUD_LAST);
    // ready_q is only ever high in IDLE, so it doubles as the IDLE qualifier.
    assign accept    = tx_valid && ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;

            if (state_q == IDLE) begin
                baud_q <= '0;
            end else begin
                baud_q <= baud_wrap ? '0 : baud_q + BAUD_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q  <= START;
                        shift_q  <= tx_data;
                        par_q    <= odd_sel ? op : ep;
                        tx_out_q <= 1'b0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        state_q  <= DATA;
                        bit_q    <= '0;
                        tx_out_q <= shift_q[0];
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_q == BIT_LAST) begin
                            state_q  <= PARITY;
                            tx_out_q <= par_q;
                        end else begin
                            // tx_out is registered, so present the bit that lands in shift_q[0] next.
                            shift_q  <= shift_q >> 1;
                            tx_out_q <= shift_q[1];
                            bit_q    <= bit_q + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (baud_wrap) begin
                        state_q  <= STOP;
                        tx_out_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_out   = tx_out_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx_ready = ready_q;

endmodule

// File: tb/tb_parity_frame_tx_ctrl.sv
// Scoreboard bench for parity_frame_tx_ctrl: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_parity_frame_tx_ctrl;

    typedef struct {
        int          dut;
        logic [11:0] f;
        int          start;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [8:0] tx_data;
    logic       odd_sel;
    logic [1:0] tx_valid_v;
    logic [1:0] tx_ready_w;
    logic [1:0] tx_out_w;
    logic [1:0] busy_w;
    logic [1:0] done_w;

    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    exp_t exp_q[$];

    parity_frame_tx_ctrl #(.CLKS_PER_BIT(4)) dut4 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_v[0]),
        .tx_ready (tx_ready_w[0]),
        .odd_sel  (odd_sel),
        .tx_out   (tx_out_w[0]),
        .busy     (busy_w[0]),
        .done     (done_w[0])
    );

    parity_frame_tx_ctrl #(.CLKS_PER_BIT(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid_v[1]),
        .tx_ready (tx_ready_w[1]),
        .odd_sel  (odd_sel),
        .tx_out   (tx_out_w[1]),
        .busy     (busy_w[1]),
        .done     (done_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Frame bit i is bit i of the vector: start, data LSB first, parity, stop.
    function automatic logic [11:0] mk(input logic [8:0] w, input logic p);
        return {1'b1, p, w, 1'b0};
    endfunction

    task automatic send(input int d, input logic [8:0] w, input logic o, input logic [11:0] f);
        int n;
        tx_data       = w;
        odd_sel       = o;
        tx_valid_v[d] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_ready_w[d] && n < 200);
        if (!tx_ready_w[d]) begin
            chk("accept_timeout", 32'(0), 32'(1));
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back('{dut: d, f: f, start: cyc_cnt});
        end
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_mon
        localparam int CPB = (g == 0) ? 4 : 1;
        initial begin : mon
            bit   act;
            bit   pend;
            int   idx;
            exp_t cur;
            act  = 1'b0;
            pend = 1'b0;
            idx  = 0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    act  = 1'b0;
                    pend = 1'b0;
                end else if (pend) begin
                    chk("done_pulse", 32'(done_w[g]), 32'(1));
                    chk("done_ready", 32'(tx_ready_w[g]), 32'(1));
                    chk("done_busy", 32'(busy_w[g]), 32'(0));
                    pend = 1'b0;
                end else begin
                    if (!act && busy_w[g]) begin
                        if (exp_q.size() == 0) begin
                            chk("unexpected_frame", 32'(1), 32'(0));
                        end else begin
                            cur = exp_q.pop_front();
                            chk("frame_dut", 32'(g), 32'(cur.dut));
                            chk("start_cycle", 32'(cyc_cnt), 32'(cur.start));
                            act = 1'b1;
                            idx = 0;
                        end
                    end
                    if (act) begin
                        chk("tx_bit", 32'(tx_out_w[g]), 32'(cur.f[idx / CPB]));
                        chk("busy_in_frame", 32'(busy_w[g]), 32'(1));
                        chk("ready_in_frame", 32'(tx_ready_w[g]), 32'(0));
                        chk("done_in_frame", 32'(done_w[g]), 32'(0));
                        idx++;
                        if (idx == parity_frame_tx_ctrl_pkg::FRAME_BITS * CPB) begin
                            act  = 1'b0;
                            pend = 1'b1;
                        end
                    end else begin
                        chk("idle_done", 32'(done_w[g]), 32'(0));
                    end
                end
            end
        end
    end

    initial begin
        bit stop;
        rst        = 1'b1;
        tx_valid_v = '0;
        tx_data    = '0;
        odd_sel    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk("rst_tx_out", 32'(tx_out_w[d]), 32'(1));
            chk("rst_busy", 32'(busy_w[d]), 32'(0));
            chk("rst_done", 32'(done_w[d]), 32'(0));
            chk("rst_ready", 32'(tx_ready_w[d]), 32'(1));
        end

        // 0x1A5 even: 0,1,0,1,0,0,1,0,1,1,1,1
        send(0, 9'h1A5, 1'b0, 12'hF4A);
        tx_valid_v[0] = 1'b0;
        idle_wait(52);

        send(0, 9'h000, 1'b1, mk(9'h000, 1'b1));
        tx_valid_v[0] = 1'b0;
        idle_wait(52);
        send(0, 9'h000, 1'b0, mk(9'h000, 1'b0));
        tx_valid_v[0] = 1'b0;
        idle_wait(52);

        // back-to-back with valid held high
        send(0, 9'h1FF, 1'b0, mk(9'h1FF, 1'b1));
        send(0, 9'h001, 1'b0, mk(9'h001, 1'b1));
        tx_valid_v[0] = 1'b0;
        idle_wait(52);

        // reset during data bit 3
        send(0, 9'h0AA, 1'b1, mk(9'h0AA, 1'b1));
        tx_valid_v[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midrst_tx_out", 32'(tx_out_w[0]), 32'(1));
        chk("midrst_busy", 32'(busy_w[0]), 32'(0));
        chk("midrst_ready", 32'(tx_ready_w[0]), 32'(1));
        chk("midrst_done", 32'(done_w[0]), 32'(0));
        idle_wait(5);
        send(0, 9'h123, 1'b0, mk(9'h123, 1'b0));
        tx_valid_v[0] = 1'b0;
        idle_wait(52);

        // inputs churn while busy; frame must carry the accepted word
        send(0, 9'h0F0, 1'b1, mk(9'h0F0, 1'b1));
        stop = 1'b0;
        for (int i = 0; i < 100 && !stop; i++) begin
            @(posedge clk);
            #1;
            tx_data = 9'($urandom);
            odd_sel = 1'($urandom);
            @(negedge clk);
            if (tx_ready_w[0]) begin
                tx_valid_v[0] = 1'b0;
                stop = 1'b1;
            end
        end
        chk("churn_ready_seen", 32'(stop), 32'(1));
        idle_wait(4);

        // one clock per bit: 0,1,0,1,0,1,0,1,0,1,1,1
        send(1, 9'h155, 1'b0, 12'hEAA);
        tx_valid_v[1] = 1'b0;
        idle_wait(20);

        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_tx_ctrl.md
Name: parity_frame_tx_ctrl

Overview:
Sequencing controller that frames 9-bit words with a parity bit and shifts them out serially. It accepts a word over a valid/ready handshake and latches it. The parity bit comes from the team's 9-bit parity generator. The frame is start bit, 9 data bits (LSB first), parity bit, stop bit, each held CLKS_PER_BIT cycles. It sits between a word producer and a single-wire serial link.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit; legal range is 1 or more.
DATA_W, 9, data word width; fixed at 9 to match the parity generator.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
tx_data  input  9  word to transmit
tx_valid  input  1  producer has a word on tx_data
tx_ready  output  1  controller can accept a word; high only in IDLE
odd_sel  input  1  0 = even parity, 1 = odd parity; sampled at acceptance
tx_out  output  1  serial line; idles high
busy  output  1  a frame is in progress (any state except IDLE)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high; it overrides all other inputs in the cycle it is sampled.
- Reset values: state=IDLE, tx_out=1, busy=0, done=0, tx_ready=1 (from the first cycle after rst is released). Baud counter, bit counter and shift register are cleared to 0.
- Accept: in IDLE, tx_valid&tx_ready at edge T latches tx_data into the shift register. At the same edge the parity bit is latched as ep when odd_sel=0, or ~ep when odd_sel=1, where ep = XOR of all 9 bits.
- tx_data and odd_sel are ignored outside the accept cycle. tx_valid while busy is ignored; the producer holds it until tx_ready.
- States: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
  - START: tx_out=0.
  - DATA: tx_out=shift[0]; right-shift at each bit boundary; bit counter counts 0..8 and exits DATA after bit 8.
  - PARITY: tx_out=latched parity.
  - STOP: tx_out=1.
- Bit timing: baud counter counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. A state or bit advances only on the wrap.
- tx_out is registered. The start bit appears in cycle T+1.
- Frame length is 12*CLKS_PER_BIT cycles, from T+1 through T+12*CLKS_PER_BIT.
- Completion: the FSM enters IDLE at T+12*CLKS_PER_BIT+1. done=1 for exactly that cycle, and tx_ready=1 in the same cycle.
- Back-to-back: a word accepted in the done cycle starts its next start bit on the following cycle. There is no extra idle bit.
- CLKS_PER_BIT=1: every state lasts one cycle and DATA lasts 9 cycles; there are no zero-length bits.
- Reset mid-frame: on the next edge the FSM returns to IDLE and tx_out goes to 1. The partial frame is abandoned, done is not pulsed, and the latched word is discarded.
- busy=1 in START, DATA, PARITY and STOP; busy=0 in IDLE, including the done cycle.

Decomposition:
- Shared package holds:
  - state enum: IDLE, START, DATA, PARITY, STOP
  - FRAME_BITS=12, DATA_W=9
  - bit counter width: 4 bits
- Baud counter width is $clog2(CLKS_PER_BIT), minimum 1.
- One sub-module: instantiate parity_generator_9_bits on tx_data and use its ep/op outputs, selected by odd_sel at acceptance.

Test Plan:
- Reset, then tx_data=9'h1A5, odd_sel=0, CLKS_PER_BIT=4 -> tx_out = 0, 1,0,1,0,0,1,0,1,1, 1 (parity), 1 (stop). Each bit lasts 4 cycles. done pulses at T+49.
- tx_data=9'h000 with odd_sel=1 -> parity bit=1. Same word with odd_sel=0 -> parity bit=0. Data bits all 0.
- Two words, 9'h1FF then 9'h001, with tx_valid held high -> second accepted in the done cycle. Second start bit at T+50. Parity bits 1 and 1 (even).
- Assert rst for 1 cycle during DATA bit 3 -> next cycle tx_out=1, busy=0, tx_ready=1, no done pulse. A new word is then framed correctly.
- Change tx_data and odd_sel every cycle while busy, with tx_valid high -> transmitted frame equals the word latched at acceptance. tx_ready stays 0 until the done cycle.
- CLKS_PER_BIT=1, tx_data=9'h155 -> 12-cycle frame 0,1,0,1,0,1,0,1,0,1,1,1. done at T+13.
